// File: rtl/nerv_mem_arbiter_pkg.sv
// Shared types and widths for the unified-memory fetch/data arbiter.
package nerv_arb_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned STRB_W   = 4;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_D
  } owner_t;

endpackage

// File: rtl/nerv_mem_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter; slave = arbiter view, master = core/memory view.
interface nerv_mem_arbiter_if;
  import nerv_arb_pkg::*;

  logic              i_valid;
  logic [XLEN-1:0]   i_addr;
  logic              i_ready;
  logic              i_rvalid;
  logic [XLEN-1:0]   i_rdata;

  logic              d_valid;
  logic [XLEN-1:0]   d_addr;
  logic [STRB_W-1:0] d_wstrb;
  logic [XLEN-1:0]   d_wdata;
  logic              d_ready;
  logic              d_rvalid;
  logic [XLEN-1:0]   d_rdata;

  logic              m_valid;
  logic [XLEN-1:0]   m_addr;
  logic [STRB_W-1:0] m_wstrb;
  logic [XLEN-1:0]   m_wdata;
  logic [XLEN-1:0]   m_rdata;

  modport slave (
    input  i_valid, i_addr, d_valid, d_addr, d_wstrb, d_wdata, m_rdata,
    output i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
           m_valid, m_addr, m_wstrb, m_wdata
  );

  modport master (
    output i_valid, i_addr, d_valid, d_addr, d_wstrb, d_wdata, m_rdata,
    input  i_ready, i_rvalid, i_rdata, d_ready, d_rvalid, d_rdata,
           m_valid, m_addr, m_wstrb, m_wdata
  );

endinterface

// File: rtl/nerv_mem_arbiter_starve_ctr.sv
// Saturating count of cycles fetch has waited; raises force_if once the limit is reached.
module nerv_arb_starve_ctr
  import nerv_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic if_wait,
  input  logic granted,
  output logic force_if
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] cnt_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (granted || !if_wait) begin
      cnt_q <= '0;
    end else if (cnt_q != '1) begin
      cnt_q <= cnt_q + STARVE_W'(1);
    end
  end

  always_comb begin
    force_if = (cnt_q >= LIMIT);
  end

endmodule

// File: rtl/nerv_mem_arbiter.sv
// Single-port memory arbiter: data-priority grant with fetch anti-starvation, 1-cycle read response routing.
// Optional NERV_ARB_PERF_EN adds grant/stall performance counters.
module nerv_mem_arbiter
  import nerv_arb_pkg::*;
#(
  parameter int unsigned     STARVE_LIMIT = 4,
  parameter logic [XLEN-1:0] RESET_ADDR   = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset,
  nerv_mem_arbiter_if.slave  bus
`ifdef NERV_ARB_PERF_EN
  ,
  output logic [31:0]        perf_if_grants,
  output logic [31:0]        perf_d_grants,
  output logic [31:0]        perf_if_stall
`endif
);

  logic   force_if;
  logic   i_grant;
  logic   d_grant;
  owner_t owner_q;
  logic   unused_addr_lsbs;

  always_comb begin
    unused_addr_lsbs = ^{bus.i_addr[1:0], bus.d_addr[1:0]};
  end

  // Grants depend only on registered state and current requests; reset low blocks all grants.
  always_comb begin
    d_grant = reset && bus.d_valid && !(force_if && bus.i_valid);
    i_grant = reset && bus.i_valid && !d_grant;
  end

  always_comb begin
    bus.i_ready = i_grant;
    bus.d_ready = d_grant;
    bus.m_valid = i_grant || d_grant;
    bus.m_addr  = RESET_ADDR;
    bus.m_wstrb = '0;
    bus.m_wdata = '0;
    if (d_grant) begin
      bus.m_addr  = {bus.d_addr[XLEN-1:2], 2'b00};
      bus.m_wstrb = bus.d_wstrb;
      bus.m_wdata = bus.d_wdata;
    end else if (i_grant) begin
      bus.m_addr  = {bus.i_addr[XLEN-1:2], 2'b00};
    end
  end

  nerv_arb_starve_ctr #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock    (clock),
    .reset    (reset),
    .if_wait  (bus.i_valid && !i_grant),
    .granted  (i_grant),
    .force_if (force_if)
  );

  // Data writes return nothing, so they leave no owner for the response cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      owner_q <= OWN_NONE;
    end else if (i_grant) begin
      owner_q <= OWN_IF;
    end else if (d_grant && (bus.d_wstrb == '0)) begin
      owner_q <= OWN_D;
    end else begin
      owner_q <= OWN_NONE;
    end
  end

  always_comb begin
    bus.i_rvalid = reset && (owner_q == OWN_IF);
    bus.d_rvalid = reset && (owner_q == OWN_D);
    bus.i_rdata  = bus.i_rvalid ? bus.m_rdata : '0;
    bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : '0;
  end

`ifdef NERV_ARB_PERF_EN
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_if_grants <= '0;
      perf_d_grants  <= '0;
      perf_if_stall  <= '0;
    end else begin
      if (i_grant)                  perf_if_grants <= perf_if_grants + 32'd1;
      if (d_grant)                  perf_d_grants  <= perf_d_grants + 32'd1;
      if (bus.i_valid && !i_grant)  perf_if_stall  <= perf_if_stall + 32'd1;
    end
  end
`endif

  a_if_hold: assert property (@(posedge clock) disable iff (!reset)
    (bus.i_valid && !i_grant) |=> bus.i_valid);
  a_d_hold: assert property (@(posedge clock) disable iff (!reset)
    (bus.d_valid && !d_grant) |=> bus.d_valid);

endmodule

// File: tb/tb_nerv_mem_arbiter.sv
// Directed bench for nerv_mem_arbiter: reset, fetch, data read/write, starvation, reset mid-read, perf counters.
module tb_nerv_mem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  nerv_mem_arbiter_if bus ();

`ifdef NERV_ARB_PERF_EN
  logic [31:0] perf_if_grants, perf_d_grants, perf_if_stall;
`endif

  nerv_mem_arbiter #(
    .STARVE_LIMIT (4),
    .RESET_ADDR   (32'hFFFF_0000)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
`ifdef NERV_ARB_PERF_EN
    ,
    .perf_if_grants (perf_if_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_if_stall  (perf_if_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.i_valid = 1'b1; bus.i_addr = 32'h0;
    bus.d_valid = 1'b1; bus.d_addr = 32'h0; bus.d_wstrb = 4'h0; bus.d_wdata = 32'h0;
    bus.m_rdata = 32'h5555_5555;

    // Reset: no grants even with both requesting
    #1;
    check("rst_iready", bus.i_ready, 0);
    check("rst_dready", bus.d_ready, 0);
    check("rst_mvalid", bus.m_valid, 0);
    check("rst_maddr",  bus.m_addr, 32'hFFFF_0000);
    check("rst_mwstrb", bus.m_wstrb, 0);
    bus.i_valid = 1'b0; bus.d_valid = 1'b0;
    tick(); tick();
    check("rst_irvalid", bus.i_rvalid, 0);
    check("rst_drvalid", bus.d_rvalid, 0);
    check("rst_irdata",  bus.i_rdata, 0);
    check("rst_drdata",  bus.d_rdata, 0);
    reset = 1'b1;
    tick();

    // Fetch only
    bus.i_valid = 1'b1; bus.i_addr = 32'h10; bus.m_rdata = 32'h0000_0013;
    #1;
    check("f_iready0", bus.i_ready, 1);
    check("f_dready0", bus.d_ready, 0);
    check("f_maddr0",  bus.m_addr, 32'h10);
    check("f_mwstrb0", bus.m_wstrb, 0);
    check("f_irv0",    bus.i_rvalid, 0);
    tick();
    check("f_iready1", bus.i_ready, 1);
    check("f_irv1",    bus.i_rvalid, 1);
    check("f_irdata1", bus.i_rdata, 32'h13);
    check("f_drv1",    bus.d_rvalid, 0);
    tick();
    bus.i_valid = 1'b0;
    #1;
    check("f_idle_mvalid", bus.m_valid, 0);
    check("f_idle_maddr",  bus.m_addr, 32'hFFFF_0000);
    check("f_irv2",        bus.i_rvalid, 1);
    tick();
    check("f_irv3",   bus.i_rvalid, 0);
    check("f_irdata3", bus.i_rdata, 0);

    // Data read against fetch: data wins, fetch follows with no bubble
    bus.i_valid = 1'b1; bus.i_addr = 32'h20;
    bus.d_valid = 1'b1; bus.d_addr = 32'h103; bus.d_wstrb = 4'h0; bus.d_wdata = 32'h1234_5678;
    bus.m_rdata = 32'hDEAD_BEEF;
    #1;
    check("dr_dready", bus.d_ready, 1);
    check("dr_iready", bus.i_ready, 0);
    check("dr_maddr",  bus.m_addr, 32'h100);
    check("dr_mwdata", bus.m_wdata, 32'h1234_5678);
    tick();
    bus.d_valid = 1'b0;
    #1;
    check("dr_drv",    bus.d_rvalid, 1);
    check("dr_drdata", bus.d_rdata, 32'hDEAD_BEEF);
    check("dr_irv",    bus.i_rvalid, 0);
    check("dr_irdata", bus.i_rdata, 0);
    check("dr_iready2", bus.i_ready, 1);
    check("dr_maddr2", bus.m_addr, 32'h20);
    tick();
    bus.i_valid = 1'b0;
    check("dr_irv2",    bus.i_rvalid, 1);
    check("dr_irdata2", bus.i_rdata, 32'hDEAD_BEEF);
    check("dr_drv2",    bus.d_rvalid, 0);

    // Data write: strobes forwarded, no response
    bus.d_valid = 1'b1; bus.d_addr = 32'h202; bus.d_wstrb = 4'b0100; bus.d_wdata = 32'h00AB_0000;
    #1;
    check("dw_dready", bus.d_ready, 1);
    check("dw_mwstrb", bus.m_wstrb, 32'h4);
    check("dw_maddr",  bus.m_addr, 32'h200);
    check("dw_mwdata", bus.m_wdata, 32'h00AB_0000);
    tick();
    bus.d_valid = 1'b0; bus.d_wstrb = 4'h0;
    #1;
    check("dw_drv",    bus.d_rvalid, 0);
    check("dw_irv",    bus.i_rvalid, 0);
    check("dw_mwdata0", bus.m_wdata, 0);
    tick();

    // Reset during the response cycle of a read
    bus.d_valid = 1'b1; bus.d_addr = 32'h400; bus.m_rdata = 32'hCAFE_F00D;
    #1;
    check("rr_dready", bus.d_ready, 1);
    tick();
    bus.d_valid = 1'b0; reset = 1'b0;
    #1;
    check("rr_drv_in_rst",  bus.d_rvalid, 0);
    check("rr_drdata_in_rst", bus.d_rdata, 0);
    tick();
    reset = 1'b1;
    #1;
    check("rr_drv_rel", bus.d_rvalid, 0);
    check("rr_irv_rel", bus.i_rvalid, 0);
    tick();
    check("rr_drv_rel2", bus.d_rvalid, 0);

    // Starvation with limit 4: D D D D I D D D D I
    bus.i_valid = 1'b1; bus.i_addr = 32'h40;
    bus.d_valid = 1'b1; bus.d_addr = 32'h300; bus.d_wstrb = 4'h0;
    bus.m_rdata = 32'h0BAD_F00D;
    for (int k = 0; k < 10; k++) begin
      logic exp_i;
      logic prev_i;
      exp_i  = (k == 4) || (k == 9);
      prev_i = (k == 5) || (k == 10);
      #1;
      check($sformatf("st_iready_%0d", k), bus.i_ready, exp_i);
      check($sformatf("st_dready_%0d", k), bus.d_ready, !exp_i);
      check($sformatf("st_maddr_%0d", k),  bus.m_addr, exp_i ? 32'h40 : 32'h300);
      check($sformatf("st_irv_%0d", k), bus.i_rvalid, (k > 0) && prev_i);
      check($sformatf("st_drv_%0d", k), bus.d_rvalid, (k > 0) && !prev_i);
      tick();
    end
`ifdef NERV_ARB_PERF_EN
    check("perf_d_grants",  perf_d_grants, 8);
    check("perf_if_grants", perf_if_grants, 2);
    check("perf_if_stall",  perf_if_stall, 8);
`endif
    #1;
    check("st_dready_10", bus.d_ready, 1);
    tick();
    bus.d_valid = 1'b0;
    #1;
    check("st_iready_11", bus.i_ready, 1);
    tick();
    bus.i_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
